// File: rtl/pipe_ctrl_pkg.sv
// Pipeline sequencer shared types.
// Stall bus layout, FSM states and counter helper.
package pipe_ctrl_pkg;

    localparam int STALL_W   = 5;
    localparam int ST_PC     = 0;
    localparam int ST_IF_ID  = 1;
    localparam int ST_ID_EX  = 2;
    localparam int ST_EX_MEM = 3;
    localparam int ST_MEM_WB = 4;

    typedef logic [STALL_W-1:0] stall_t;

    localparam stall_t STALL_NONE  = 5'b00000;
    localparam stall_t STALL_FRONT = 5'b00011;
    localparam stall_t STALL_EX    = 5'b00111;
    localparam stall_t STALL_ALL   = 5'b11111;

    typedef enum logic [2:0] {
        S_RUN,
        S_FLUSH,
        S_BUSY,
        S_DRAIN,
        S_HALT
    } state_t;

    function automatic logic [31:0] sat_inc(
        input logic [31:0] v,
        input logic        en
    );
        return (en && v != 32'hFFFF_FFFF) ? v + 32'd1 : v;
    endfunction

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard compare between ID sources and EX load.
// x0 never creates a hazard.
module pipe_ctrl_hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic       id_reg1_re,
    input  logic [4:0] id_reg1_raddr,
    input  logic       id_reg2_re,
    input  logic [4:0] id_reg2_raddr,
    input  logic       ex_we,
    input  logic [4:0] ex_waddr,
    input  logic       ex_is_load,
    output logic       load_use
);

    logic ex_ld_wr;
    logic rs1_hit;
    logic rs2_hit;

    assign ex_ld_wr = ex_is_load & ex_we & (ex_waddr != 5'd0);
    assign rs1_hit  = id_reg1_re & (id_reg1_raddr == ex_waddr);
    assign rs2_hit  = id_reg2_re & (id_reg2_raddr == ex_waddr);
    assign load_use = ex_ld_wr & (rs1_hit | rs2_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: stalls, flushes, PC redirect, debug halt.
// Mealy outputs from state + inputs; forced to 0 while in reset.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int BUSY_TIMEOUT = 64,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         id_reg1_re,
    input  logic [4:0]   id_reg1_raddr,
    input  logic         id_reg2_re,
    input  logic [4:0]   id_reg2_raddr,
    input  logic         ex_we,
    input  logic [4:0]   ex_waddr,
    input  logic         ex_is_load,
    input  logic         ex_busy,
    input  logic         ex_jump_req,
    input  logic [31:0]  ex_jump_addr,
    input  logic         halt_req,
    output logic         halt_ack,
    output logic [4:0]   stall,
    output logic         flush_if_id,
    output logic         flush_id_ex,
    output logic         flush_ex_mem,
    output logic         jump_o,
    output logic [31:0]  jump_addr_o,
    output logic         busy_timeout,
    output logic [31:0]  stall_cnt
);

    localparam int FW = $clog2(FLUSH_CYCLES + 1);
    localparam int BW = $clog2(BUSY_TIMEOUT + 1);
    localparam int DW = $clog2(DRAIN_CYCLES + 1);

    state_t        state, state_nxt;
    logic [FW-1:0] flush_cnt, flush_cnt_nxt;
    logic [BW-1:0] busy_cnt, busy_cnt_nxt;
    logic [DW-1:0] drain_cnt, drain_cnt_nxt;
    logic          load_use;
    logic          use_run;

    pipe_ctrl_hazard_detect u_hazard (
        .id_reg1_re    (id_reg1_re),
        .id_reg1_raddr (id_reg1_raddr),
        .id_reg2_re    (id_reg2_re),
        .id_reg2_raddr (id_reg2_raddr),
        .ex_we         (ex_we),
        .ex_waddr      (ex_waddr),
        .ex_is_load    (ex_is_load),
        .load_use      (load_use)
    );

    // State, phase counters and saturating stall counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_RUN;
            flush_cnt <= '0;
            busy_cnt  <= '0;
            drain_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            state     <= state_nxt;
            flush_cnt <= flush_cnt_nxt;
            busy_cnt  <= busy_cnt_nxt;
            drain_cnt <= drain_cnt_nxt;
            stall_cnt <= sat_inc(stall_cnt, |stall);
        end
    end

    // Next state and outputs; FLUSH/BUSY fall back to RUN decisions.
    always_comb begin
        state_nxt     = state;
        flush_cnt_nxt = flush_cnt;
        busy_cnt_nxt  = busy_cnt;
        drain_cnt_nxt = drain_cnt;
        stall         = STALL_NONE;
        flush_if_id   = 1'b0;
        flush_id_ex   = 1'b0;
        flush_ex_mem  = 1'b0;
        jump_o        = 1'b0;
        jump_addr_o   = '0;
        halt_ack      = 1'b0;
        busy_timeout  = 1'b0;
        use_run       = 1'b0;
        if (rst) begin
            unique case (state)
                S_RUN: use_run = 1'b1;
                S_FLUSH: begin
                    if (ex_jump_req) begin
                        use_run = 1'b1;
                    end else begin
                        flush_if_id = 1'b1;
                        if (int'(flush_cnt) >= FLUSH_CYCLES - 1)
                            state_nxt = S_RUN;
                        else
                            flush_cnt_nxt = flush_cnt + FW'(1);
                    end
                end
                S_BUSY: begin
                    if (!ex_busy) begin
                        use_run = 1'b1;
                    end else if (busy_cnt == BW'(BUSY_TIMEOUT)) begin
                        busy_timeout = 1'b1;
                        flush_id_ex  = 1'b1;
                        state_nxt    = S_RUN;
                    end else begin
                        stall        = STALL_EX;
                        flush_ex_mem = 1'b1;
                        busy_cnt_nxt = busy_cnt + BW'(1);
                    end
                end
                S_DRAIN: begin
                    if (!halt_req) begin
                        state_nxt = S_RUN;
                    end else begin
                        stall       = STALL_FRONT;
                        flush_id_ex = 1'b1;
                        if (int'(drain_cnt) + 1 >= DRAIN_CYCLES)
                            state_nxt = S_HALT;
                        else
                            drain_cnt_nxt = drain_cnt + DW'(1);
                    end
                end
                S_HALT: begin
                    if (halt_req) begin
                        stall    = STALL_ALL;
                        halt_ack = 1'b1;
                    end else begin
                        state_nxt = S_RUN;
                    end
                end
                default: state_nxt = S_RUN;
            endcase
            if (use_run) begin
                state_nxt = S_RUN;
                if (ex_jump_req) begin
                    jump_o        = 1'b1;
                    jump_addr_o   = ex_jump_addr;
                    flush_if_id   = 1'b1;
                    flush_id_ex   = 1'b1;
                    flush_cnt_nxt = FW'(1);
                    if (FLUSH_CYCLES > 1)
                        state_nxt = S_FLUSH;
                end else if (ex_busy) begin
                    stall        = STALL_EX;
                    flush_ex_mem = 1'b1;
                    busy_cnt_nxt = BW'(1);
                    state_nxt    = S_BUSY;
                end else if (halt_req) begin
                    stall         = STALL_FRONT;
                    flush_id_ex   = 1'b1;
                    drain_cnt_nxt = DW'(1);
                    state_nxt     = (DRAIN_CYCLES > 1) ? S_DRAIN : S_HALT;
                end else if (load_use) begin
                    stall       = STALL_FRONT;
                    flush_id_ex = 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios plus random traffic
// against a phase-counting reference model.
module tb_pipe_ctrl;

    localparam int FC = 2;
    localparam int BT = 64;
    localparam int DC = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_reg1_re, id_reg2_re;
    logic [4:0]  id_reg1_raddr, id_reg2_raddr;
    logic        ex_we, ex_is_load, ex_busy, ex_jump_req;
    logic [4:0]  ex_waddr;
    logic [31:0] ex_jump_addr;
    logic        halt_req;
    logic        halt_ack;
    logic [4:0]  stall;
    logic        flush_if_id, flush_id_ex, flush_ex_mem;
    logic        jump_o, busy_timeout;
    logic [31:0] jump_addr_o, stall_cnt;

    always #5 clk = ~clk;

    pipe_ctrl #(
        .FLUSH_CYCLES (FC),
        .BUSY_TIMEOUT (BT),
        .DRAIN_CYCLES (DC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .id_reg1_re    (id_reg1_re),
        .id_reg1_raddr (id_reg1_raddr),
        .id_reg2_re    (id_reg2_re),
        .id_reg2_raddr (id_reg2_raddr),
        .ex_we         (ex_we),
        .ex_waddr      (ex_waddr),
        .ex_is_load    (ex_is_load),
        .ex_busy       (ex_busy),
        .ex_jump_req   (ex_jump_req),
        .ex_jump_addr  (ex_jump_addr),
        .halt_req      (halt_req),
        .halt_ack      (halt_ack),
        .stall         (stall),
        .flush_if_id   (flush_if_id),
        .flush_id_ex   (flush_id_ex),
        .flush_ex_mem  (flush_ex_mem),
        .jump_o        (jump_o),
        .jump_addr_o   (jump_addr_o),
        .busy_timeout  (busy_timeout),
        .stall_cnt     (stall_cnt)
    );

    logic [42:0] obs, exp_v;
    assign obs = {halt_ack, stall, flush_if_id, flush_id_ex,
                  flush_ex_mem, jump_o, jump_addr_o, busy_timeout};

    int n_vec = 0;
    int n_err = 0;

    int     m_flush_left, m_busy_len, m_drain;
    bit     m_halt;
    longint m_scnt;
    int     n_flush_left, n_busy_len, n_drain;
    bit     n_halt;

    logic        e_ack, e_fif, e_fie, e_fem, e_jmp, e_to;
    logic [4:0]  e_stall;
    logic [31:0] e_addr;

    task automatic model_reset();
        m_flush_left = 0;
        m_busy_len   = 0;
        m_drain      = 0;
        m_halt       = 0;
        m_scnt       = 0;
    endtask

    task automatic run_rules();
        bit lu;
        lu = ex_is_load && ex_we && ex_waddr != 0 &&
             ((id_reg1_re && id_reg1_raddr == ex_waddr) ||
              (id_reg2_re && id_reg2_raddr == ex_waddr));
        if (ex_jump_req) begin
            e_jmp = 1; e_addr = ex_jump_addr;
            e_fif = 1; e_fie = 1;
            n_flush_left = FC - 1;
        end else if (ex_busy) begin
            e_stall = 5'b00111; e_fem = 1;
            n_busy_len = 1;
        end else if (halt_req) begin
            e_stall = 5'b00011; e_fie = 1;
            if (DC > 1) n_drain = 1;
            else n_halt = 1;
        end else if (lu) begin
            e_stall = 5'b00011; e_fie = 1;
        end
    endtask

    // Settles inputs, then computes expected outputs and next phase.
    task automatic model_comb();
        #2;
        e_ack = 0; e_fif = 0; e_fie = 0; e_fem = 0;
        e_jmp = 0; e_to = 0; e_stall = 0; e_addr = 0;
        n_flush_left = m_flush_left;
        n_busy_len   = m_busy_len;
        n_drain      = m_drain;
        n_halt       = m_halt;
        if (!rst) begin
        end else if (m_halt) begin
            if (halt_req) begin
                e_stall = 5'b11111; e_ack = 1;
            end else n_halt = 0;
        end else if (m_drain > 0) begin
            if (!halt_req) n_drain = 0;
            else begin
                e_stall = 5'b00011; e_fie = 1;
                n_drain = m_drain + 1;
                if (n_drain >= DC) begin
                    n_drain = 0; n_halt = 1;
                end
            end
        end else if (m_busy_len > 0) begin
            n_busy_len = 0;
            if (!ex_busy) run_rules();
            else if (m_busy_len == BT) begin
                e_to = 1; e_fie = 1;
            end else begin
                e_stall = 5'b00111; e_fem = 1;
                n_busy_len = m_busy_len + 1;
            end
        end else if (m_flush_left > 0) begin
            if (ex_jump_req) run_rules();
            else begin
                e_fif = 1;
                n_flush_left = m_flush_left - 1;
            end
        end else run_rules();
        exp_v = {e_ack, e_stall, e_fif, e_fie, e_fem,
                 e_jmp, e_addr, e_to};
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) model_reset();
        else begin
            m_flush_left = n_flush_left;
            m_busy_len   = n_busy_len;
            m_drain      = n_drain;
            m_halt       = n_halt;
            if (e_stall != 0 && m_scnt < 64'hFFFF_FFFF) m_scnt++;
        end
        #1;
    endtask

    task automatic clr_in();
        id_reg1_re = 0; id_reg1_raddr = 0;
        id_reg2_re = 0; id_reg2_raddr = 0;
        ex_we = 0; ex_waddr = 0; ex_is_load = 0;
        ex_busy = 0; ex_jump_req = 0; ex_jump_addr = 0;
        halt_req = 0;
    endtask

    task automatic test_reset();
        clr_in();
        rst = 0;
        model_reset();
        ex_busy = 1; ex_jump_req = 1; ex_jump_addr = 32'hDEAD_BEEF;
        halt_req = 1;
        model_comb();
        n_vec++;
        if (obs !== 43'd0 || stall_cnt !== 32'd0) begin
            n_err++;
            $display("FAIL reset: got %h/%0d want 0/0", obs, stall_cnt);
        end
        tick();
        tick();
        clr_in();
        rst = 1;
        model_comb();
        n_vec++;
        if (obs !== exp_v || stall_cnt !== m_scnt[31:0]) begin
            n_err++;
            $display("FAIL reset_idle: got %h/%0d want %h/%0d",
                     obs, stall_cnt, exp_v, m_scnt);
        end
        tick();
    endtask

    task automatic test_load_use();
        logic [4:0] want_st [4];
        want_st[0] = 5'b00011;
        want_st[1] = 5'b00000;
        want_st[2] = 5'b00000;
        want_st[3] = 5'b00000;
        for (int i = 0; i < 4; i++) begin
            clr_in();
            unique case (i)
                0: begin
                    ex_is_load = 1; ex_we = 1; ex_waddr = 5;
                    id_reg1_re = 1; id_reg1_raddr = 5;
                    id_reg2_re = 1; id_reg2_raddr = 2;
                end
                1: begin
                    id_reg1_re = 1; id_reg1_raddr = 5;
                    id_reg2_re = 1; id_reg2_raddr = 2;
                end
                2: begin
                    ex_is_load = 1; ex_we = 1; ex_waddr = 0;
                    id_reg1_re = 1; id_reg1_raddr = 0;
                    id_reg2_re = 1; id_reg2_raddr = 2;
                end
                default: begin
                    ex_is_load = 1; ex_we = 1; ex_waddr = 9;
                    id_reg1_re = 1; id_reg1_raddr = 7;
                    id_reg2_re = 0; id_reg2_raddr = 9;
                end
            endcase
            model_comb();
            n_vec++;
            if (stall !== want_st[i] ||
                flush_id_ex !== (i == 0)) begin
                n_err++;
                $display("FAIL load_use_%0d: got st=%b fie=%b want st=%b",
                         i, stall, flush_id_ex, want_st[i]);
            end
            n_vec++;
            if (obs !== exp_v || stall_cnt !== m_scnt[31:0]) begin
                n_err++;
                $display("FAIL load_use_m%0d: got %h/%0d want %h/%0d",
                         i, obs, stall_cnt, exp_v, m_scnt);
            end
            tick();
        end
    endtask

    task automatic test_jump();
        int nj = 0;
        int nf = 0;
        for (int i = 0; i < 4; i++) begin
            clr_in();
            if (i == 0) begin
                ex_jump_req = 1; ex_jump_addr = 32'h0000_0100;
            end
            model_comb();
            if (jump_o && jump_addr_o == 32'h0000_0100) nj++;
            if (flush_if_id) nf++;
            n_vec++;
            if (obs !== exp_v || stall_cnt !== m_scnt[31:0]) begin
                n_err++;
                $display("FAIL jump_c%0d: got %h/%0d want %h/%0d",
                         i, obs, stall_cnt, exp_v, m_scnt);
            end
            tick();
        end
        n_vec++;
        if (nj != 1 || nf != FC) begin
            n_err++;
            $display("FAIL jump_len: got jump=%0d flush=%0d want 1/%0d",
                     nj, nf, FC);
        end
    endtask

    task automatic test_busy();
        logic [31:0] c0;
        int ns = 0;
        c0 = stall_cnt;
        for (int i = 0; i < 7; i++) begin
            clr_in();
            ex_busy = (i < 5);
            ex_jump_req = (i == 2);
            ex_jump_addr = 32'h0000_0440;
            model_comb();
            if (stall == 5'b00111 && flush_ex_mem) ns++;
            n_vec++;
            if (obs !== exp_v || stall_cnt !== m_scnt[31:0]) begin
                n_err++;
                $display("FAIL busy_c%0d: got %h/%0d want %h/%0d",
                         i, obs, stall_cnt, exp_v, m_scnt);
            end
            tick();
        end
        n_vec++;
        if (ns != 5 || stall_cnt - c0 != 32'd5) begin
            n_err++;
            $display("FAIL busy_len: got %0d/+%0d want 5/+5",
                     ns, stall_cnt - c0);
        end
    endtask

    task automatic test_timeout();
        int at = -1;
        for (int i = 0; i < BT + 4; i++) begin
            clr_in();
            ex_busy = 1;
            model_comb();
            if (busy_timeout && at < 0) at = i;
            n_vec++;
            if (obs !== exp_v || stall_cnt !== m_scnt[31:0]) begin
                n_err++;
                $display("FAIL timeout_c%0d: got %h/%0d want %h/%0d",
                         i, obs, stall_cnt, exp_v, m_scnt);
            end
            tick();
        end
        n_vec++;
        if (at != BT) begin
            n_err++;
            $display("FAIL timeout_at: got cycle %0d want %0d", at, BT);
        end
        clr_in();
        for (int i = 0; i < 3; i++) begin
            model_comb();
            tick();
        end
    endtask

    task automatic test_halt_busy();
        int nd = 0;
        int k = 0;
        for (int i = 0; i < 4; i++) begin
            clr_in();
            ex_busy = 1; halt_req = 1;
            model_comb();
            n_vec++;
            if (obs !== exp_v || halt_ack !== 1'b0) begin
                n_err++;
                $display("FAIL halt_wait_c%0d: got %h want %h",
                         i, obs, exp_v);
            end
            tick();
        end
        ex_busy = 0;
        while (k < 20) begin
            model_comb();
            n_vec++;
            if (obs !== exp_v || stall_cnt !== m_scnt[31:0]) begin
                n_err++;
                $display("FAIL halt_drain_c%0d: got %h/%0d want %h/%0d",
                         k, obs, stall_cnt, exp_v, m_scnt);
            end
            if (halt_ack) break;
            if (stall == 5'b00011 && flush_id_ex) nd++;
            tick();
            k++;
        end
        n_vec++;
        if (k >= 20 || nd != DC) begin
            n_err++;
            $display("FAIL halt_ack: got drain=%0d k=%0d want %0d",
                     nd, k, DC);
        end
        tick();
        model_comb();
        n_vec++;
        if (stall !== 5'b11111 || halt_ack !== 1'b1) begin
            n_err++;
            $display("FAIL halt_hold: got st=%b ack=%b want 11111/1",
                     stall, halt_ack);
        end
        rst = 0;
        model_reset();
        #1;
        n_vec++;
        if (obs !== 43'd0 || stall_cnt !== 32'd0) begin
            n_err++;
            $display("FAIL halt_rst: got %h/%0d want 0/0",
                     obs, stall_cnt);
        end
        tick();
        clr_in();
        rst = 1;
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            id_reg1_re    = $urandom_range(0, 1) == 1;
            id_reg2_re    = $urandom_range(0, 1) == 1;
            id_reg1_raddr = 5'($urandom_range(0, 3));
            id_reg2_raddr = 5'($urandom_range(0, 3));
            ex_we         = $urandom_range(0, 3) != 0;
            ex_is_load    = $urandom_range(0, 1) == 1;
            ex_waddr      = 5'($urandom_range(0, 3));
            ex_jump_req   = $urandom_range(0, 9) == 0;
            ex_jump_addr  = $urandom;
            if (ex_busy) ex_busy = $urandom_range(0, 7) != 0;
            else ex_busy = $urandom_range(0, 11) == 0;
            if ($urandom_range(0, 29) == 0) halt_req = !halt_req;
            model_comb();
            n_vec++;
            if (obs !== exp_v || stall_cnt !== m_scnt[31:0]) begin
                n_err++;
                $display("FAIL random_c%0d: got %h/%0d want %h/%0d",
                         i, obs, stall_cnt, exp_v, m_scnt);
            end
            tick();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_load_use();
        test_jump();
        test_busy();
        test_timeout();
        test_halt_busy();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
